// File: rtl/inc_share_arbiter.sv
// inc_share_arbiter
//   One registered WIDTH-bit incrementer shared by NUM_REQ requesters.
//   A round-robin arbiter picks one requester per accepted cycle. The result
//   register is single-entry and can be popped and reloaded in one cycle,
//   so throughput is one result per cycle.
//   Each result is tagged with the winning requester index and a carry flag.
//
//   Build option: define INC_SHARE_SAT_EN for a saturating increment, where an
//   all-ones operand stays all-ones. By default the result wraps to zero.
//   rsp_carry is 1 for an all-ones operand in both modes.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | result register empty; a winning request is accepted
//   ST_FULL  | result register holds a result; accept only when popped

module inc_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic [ID_W-1:0]            rsp_id,
  output logic                       rsp_carry
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              carry_q, carry_d;

  logic              can_accept;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   scan_idx;
  logic [NUM_REQ-1:0] grant_vec;
  logic [WIDTH-1:0]  grant_op;
  logic [WIDTH-1:0]  inc_result;
  logic              op_all_ones;

  // Requester index after idx, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) begin
      return '0;
    end
    return idx + ID_W'(1);
  endfunction

  // Reset blocks all grants. A full register accepts only in a cycle where it is popped.
  assign can_accept = rst && ((state_q == ST_EMPTY) || rsp_ready);

  // Round-robin search starting at rr_ptr; the first valid requester found wins.
  always_comb begin
    grant_vec   = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_idx    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && can_accept && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
      scan_idx = next_idx(scan_idx);
    end
    if (grant_found) begin
      grant_vec[grant_idx] = 1'b1;
    end
  end

  assign req_ready = grant_vec;

  // Select the winner's operand and form its increment.
  always_comb begin
    grant_op    = req_data[grant_idx*WIDTH +: WIDTH];
    op_all_ones = &grant_op;
`ifdef INC_SHARE_SAT_EN
    inc_result  = op_all_ones ? grant_op : grant_op + WIDTH'(1);
`else
    inc_result  = grant_op + WIDTH'(1);
`endif
  end

  // Next state: load on grant, drain on pop without grant, otherwise hold.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
    carry_d  = carry_q;
    case (state_q)
      ST_EMPTY: begin
        if (grant_found) begin
          state_d  = ST_FULL;
          data_d   = inc_result;
          id_d     = grant_idx;
          carry_d  = op_all_ones;
          rr_ptr_d = next_idx(grant_idx);
        end
      end
      ST_FULL: begin
        if (rsp_ready) begin
          if (grant_found) begin
            data_d   = inc_result;
            id_d     = grant_idx;
            carry_d  = op_all_ones;
            rr_ptr_d = next_idx(grant_idx);
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and result registers. Reset drops any held result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
      carry_q  <= carry_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_carry = carry_q;

endmodule

// File: tb/tb_inc_share_arbiter.sv
// Bench for inc_share_arbiter: directed scenarios followed by constrained-random
// traffic, all compared cycle by cycle against a behavioural model.

module tb_inc_share_arbiter;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_carry;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_id;
  bit               m_carry;
  int               m_ptr;
  logic [NUM_REQ-1:0] last_grant;

  logic [WIDTH-1:0] snap_data;
  logic [ID_W-1:0]  snap_id;
  logic [WIDTH-1:0] exp_sat;
  int               exp_ids [5] = '{0, 1, 2, 3, 0};

  inc_share_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_carry (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_inc(input logic [WIDTH-1:0] d);
`ifdef INC_SHARE_SAT_EN
    if (d == {WIDTH{1'b1}}) return d;
`endif
    return d + WIDTH'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] model_grant();
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (rst && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (req_valid[i]) begin
          g[i] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [WIDTH-1:0] d);
    req_valid[i] = v;
    req_data[i*WIDTH +: WIDTH] = d;
  endtask

  // Compare every DUT output with the model, away from the rising edge.
  task automatic sample();
    @(negedge clk);
    last_grant = model_grant();
    chk("req_ready", 32'(req_ready), 32'(last_grant));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("rsp_data",  32'(rsp_data),  32'(m_data));
    chk("rsp_id",    32'(rsp_id),    32'(m_id));
    chk("rsp_carry", 32'(rsp_carry), 32'(m_carry));
  endtask

  // Apply the rising edge to the model and the DUT.
  task automatic advance();
    logic [WIDTH-1:0] op;
    if (!rst) begin
      m_valid = 0; m_data = '0; m_id = 0; m_carry = 0; m_ptr = 0;
    end else if (last_grant != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (last_grant[i]) begin
          op      = req_data[i*WIDTH +: WIDTH];
          m_data  = model_inc(op);
          m_carry = (op == {WIDTH{1'b1}});
          m_id    = i;
          m_valid = 1;
          m_ptr   = (i + 1) % NUM_REQ;
        end
      end
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    m_valid = 0; m_data = '0; m_id = 0; m_carry = 0; m_ptr = 0;
    last_grant = '0;
    rst       = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(posedge clk);
    #1;

    // reset held with every requester asking
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, WIDTH'($urandom));
    repeat (2) begin
      sample();
      chk("t1_ready_in_reset", 32'(req_ready), 32'h0);
      chk("t1_valid_in_reset", 32'(rsp_valid), 32'h0);
      chk("t1_data_in_reset",  32'(rsp_data),  32'h0);
      advance();
    end
    rst = 1'b1;
    sample();
    chk("t1_first_grant", 32'(req_ready), 32'h1);
    advance();
    req_valid = '0;
    cycle();
    cycle();

    // single requester 1 with a small operand
    set_req(1, 1'b1, 16'h000B);
    cycle();
    req_valid = '0;
    sample();
    chk("t2_valid", 32'(rsp_valid), 32'h1);
    chk("t2_data",  32'(rsp_data),  32'h000C);
    chk("t2_id",    32'(rsp_id),    32'h1);
    chk("t2_carry", 32'(rsp_carry), 32'h0);
    advance();

    // all-ones operand
    set_req(0, 1'b1, 16'hFFFF);
    cycle();
    req_valid = '0;
`ifdef INC_SHARE_SAT_EN
    exp_sat = 16'hFFFF;
`else
    exp_sat = 16'h0000;
`endif
    sample();
    chk("t3_data",  32'(rsp_data),  32'(exp_sat));
    chk("t3_carry", 32'(rsp_carry), 32'h1);
    advance();

    // all requesters continuously valid, consumer always ready
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, WIDTH'($urandom));
    cycle();
    for (int k = 0; k < 5; k++) begin
      sample();
      chk("t4_valid", 32'(rsp_valid), 32'h1);
      chk("t4_id",    32'(rsp_id),    32'(exp_ids[k]));
      advance();
    end

    // backpressure for three cycles, then pop and grant together
    rsp_ready = 1'b0;
    sample();
    snap_data = rsp_data;
    snap_id   = rsp_id;
    advance();
    repeat (3) begin
      sample();
      chk("t5_ready_stalled", 32'(req_ready), 32'h0);
      chk("t5_valid_held",    32'(rsp_valid), 32'h1);
      chk("t5_data_held",     32'(rsp_data),  32'(snap_data));
      chk("t5_id_held",       32'(rsp_id),    32'(snap_id));
      advance();
    end
    rsp_ready = 1'b1;
    sample();
    chk("t5_grant_on_pop", 32'($countones(req_ready)), 32'h1);
    advance();
    sample();
    chk("t5_valid_after_pop", 32'(rsp_valid), 32'h1);
    advance();

    // reset while full and stalled
    rsp_ready = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    sample();
    chk("t6_valid_dropped", 32'(rsp_valid), 32'h0);
    chk("t6_ptr_zero",      32'(req_ready), 32'h1);
    advance();
    rsp_ready = 1'b1;

    // random traffic; requesters hold valid/data until granted
    for (int n = 0; n < 400; n++) begin
      cycle();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || last_grant[i]) begin
          set_req(i, $urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 16'hFFFF : WIDTH'($urandom));
        end
      end
      rsp_ready = $urandom_range(0, 3) != 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
